// File: rtl/spi_dat_pkg.sv
// -----------------------------------------------------------------------------
// spi_dat_pkg
// Shared constants for the SPI data-exchange sink:
//   DW_DEF       default frame length in bits
//   TX_DAT_DEF   default slave word returned on MISO
//   EXP_DAT_DEF  default master word the compare logic expects
//   ST_*         FSM state encoding of spi_dat_sink
//   sat_inc8     saturating 8-bit increment used by the mismatch counter
// -----------------------------------------------------------------------------
package spi_dat_pkg;

  localparam int          DW_DEF      = 12;
  localparam logic [11:0] TX_DAT_DEF  = 12'hE6C;
  localparam logic [11:0] EXP_DAT_DEF = 12'h702;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// -----------------------------------------------------------------------------
// spi_in_sync
// Two-flop synchroniser for an asynchronous pin followed by a previous-value
// register, giving single-clk rise/fall strobes in the clk domain.
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset (all flops load RST_VAL)
//   d_i     asynchronous input pin
//   sync_o  synchronised level
//   rise_o  one-clk strobe on a synchronised 0->1 transition
//   fall_o  one-clk strobe on a synchronised 1->0 transition
// -----------------------------------------------------------------------------
module spi_in_sync
  import spi_dat_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old value
      // of the stage before it; blocking here would collapse the chain.
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_dat_sink.sv
// -----------------------------------------------------------------------------
// spi_dat_sink
// SPI mode-0 slave at the receive end of the 12-bit master/slave exchange.
// All SPI pins are oversampled in the clk domain (clk >= 8x SCK). Captures the
// master word MSB first, returns TX_DAT on MISO and reports frame status.
//
// Optional feature (macro SPI_DAT_CHECK_EN):
//   defined   -> received word compared with EXP_DAT; match and a saturating
//                mismatch counter err_cnt are built
//   undefined -> no compare logic; match and err_cnt tied to 0
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   sck        SPI clock from the master (asynchronous)
//   ss_n       slave select, active low (asynchronous)
//   mosi       master-to-slave serial data (asynchronous)
//   miso       slave-to-master serial data, 0 outside a frame
//   rx_dat     last completed received word
//   rx_valid   one-clk pulse when a full frame is received
//   frame_err  one-clk pulse when ss_n rises before DW bits arrived
//   match      rx_dat == EXP_DAT, updated with rx_valid
//   err_cnt    saturating count of mismatched frames
// -----------------------------------------------------------------------------
module spi_dat_sink
  import spi_dat_pkg::*;
#(
  parameter int          DW      = DW_DEF,
  parameter logic [DW-1:0] TX_DAT  = DW'(TX_DAT_DEF),
  parameter logic [DW-1:0] EXP_DAT = DW'(EXP_DAT_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sck,
  input  logic          ss_n,
  input  logic          mosi,
  output logic          miso,
  output logic [DW-1:0] rx_dat,
  output logic          rx_valid,
  output logic          frame_err,
  output logic          match,
  output logic [7:0]    err_cnt
);

  localparam int            CW       = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

  // ---------------------------------------------------------------------------
  // Input synchronisation
  // ---------------------------------------------------------------------------
  logic sck_rise, sck_fall, unused_sck_sync;
  logic ss_sync, ss_rise, ss_fall;
  logic mosi_meta_q, mosi_sync_q;

  spi_in_sync #(.RST_VAL(1'b0)) u_sck_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sck),
    .sync_o (unused_sck_sync),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_in_sync #(.RST_VAL(1'b1)) u_ss_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (ss_n),
    .sync_o (ss_sync),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] tx_shift_q, tx_shift_d;
  // Only DW-1 bits are stored: the last bit goes straight into rx_dat.
  logic [DW-2:0] rx_shift_q, rx_shift_d;
  logic [DW-1:0] rx_dat_q, rx_dat_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [DW-1:0] rx_word;

  // The ss_n chain resets to 1, so with ss_n held low through reset it shows
  // a fall once real samples arrive. settle_q marks when the chain holds real
  // samples; armed_q then requires ss_n to be seen high before a frame may
  // start.
  logic [1:0] settle_q;
  logic       armed_q;

  assign rx_word = {rx_shift_q, mosi_sync_q};

  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_dat_d    = rx_dat_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ss_fall && armed_q) begin
          state_d    = ST_SHIFT;
          tx_shift_d = TX_DAT;
          bit_cnt_d  = '0;
        end
      end

      ST_SHIFT: begin
        // ss_n rising wins over any sck edge in the same clk.
        if (ss_rise) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          if (sck_rise) begin
            rx_shift_d = rx_word[DW-2:0];
            bit_cnt_d  = bit_cnt_q + CW'(1);
            if (bit_cnt_q == LAST_BIT) begin
              state_d    = ST_DONE;
              rx_dat_d   = rx_word;
              rx_valid_d = 1'b1;
            end
          end
          if (sck_fall) begin
            tx_shift_d = {tx_shift_q[DW-2:0], 1'b0};
          end
        end
      end

      ST_DONE: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_dat_q    <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      settle_q    <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_dat_q    <= rx_dat_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      mosi_meta_q <= mosi;
      mosi_sync_q <= mosi_meta_q;
      settle_q    <= {settle_q[0], 1'b1};
      armed_q     <= armed_q | (settle_q[1] & ss_sync);
    end
  end

  assign miso      = (state_q == ST_SHIFT) & tx_shift_q[DW-1];
  assign rx_dat    = rx_dat_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

  // ---------------------------------------------------------------------------
  // Optional compare logic
  // ---------------------------------------------------------------------------
`ifdef SPI_DAT_CHECK_EN
  logic       match_q;
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      match_q   <= 1'b0;
      err_cnt_q <= '0;
    end else if (rx_valid_d) begin
      match_q <= (rx_dat_d == EXP_DAT);
      if (rx_dat_d != EXP_DAT) begin
        err_cnt_q <= sat_inc8(err_cnt_q);
      end
    end
  end

  assign match   = match_q;
  assign err_cnt = err_cnt_q;
`else
  logic unused_exp_dat;
  assign unused_exp_dat = ^EXP_DAT;

  assign match   = 1'b0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_spi_dat_sink.sv
// -----------------------------------------------------------------------------
// tb_spi_dat_sink
// Self-checking bench for spi_dat_sink. A behavioural SPI master drives frames;
// a reference model derived from the frame-level rules predicts rx_dat,
// rx_valid/frame_err pulse counts, match, err_cnt, the MISO word and the
// sck-to-rx_valid latency.
// -----------------------------------------------------------------------------
module tb_spi_dat_sink;

  localparam int          DW      = 12;
  localparam logic [11:0] TX_DAT  = 12'hE6C;
  localparam logic [11:0] EXP_DAT = 12'h702;
`ifdef SPI_DAT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          sck;
  logic          ss_n;
  logic          mosi;
  logic          miso;
  logic [DW-1:0] rx_dat;
  logic          rx_valid;
  logic          frame_err;
  logic          match;
  logic [7:0]    err_cnt;

  spi_dat_sink dut (
    .clk       (clk),
    .rst       (rst),
    .sck       (sck),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .miso      (miso),
    .rx_dat    (rx_dat),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .match     (match),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // Cycle counter and pulse monitors
  int cyc       = 0;
  int valid_cnt = 0;
  int ferr_cnt  = 0;
  int valid_cyc = 0;
  int last_rise_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
  end

  // Scoreboard counts
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [11:0] exp_rx    = '0;
  logic        exp_match = 1'b0;
  int          exp_err   = 0;

  // One SCK period, mode 0: data set up while SCK is low, master samples MISO
  // just before its own rising edge. All pin changes happen on clk negedges.
  task automatic drive_bit(input logic b, input int half, output logic mb);
    mosi = b;
    repeat (half) @(negedge clk);
    mb = miso;
    sck = 1'b1;
    last_rise_cyc = cyc;
    repeat (half) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic send_frame(input logic [11:0] word, input int nbits, input int half);
    int          v0, f0, rise_last, nfull;
    logic        mb, extra_or;
    logic [11:0] miso_word, exp_miso;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    miso_word = '0;
    extra_or = 1'b0;
    rise_last = 0;
    ss_n = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i < DW) begin
        drive_bit(word[DW-1-i], half, mb);
        miso_word = {miso_word[10:0], mb};
        if (i == DW - 1) rise_last = last_rise_cyc;
      end else begin
        drive_bit(1'($urandom), half, mb);
        extra_or = extra_or | mb;
      end
    end
    repeat (half) @(negedge clk);
    ss_n = 1'b1;
    repeat (2 * half + 6) @(negedge clk);

    // Model: a frame of DW or more bits delivers the first DW bits exactly once.
    nfull = (nbits >= DW) ? 1 : 0;
    if (nbits >= DW) begin
      exp_rx    = word;
      exp_match = CHECK_EN && (word == EXP_DAT);
      if (CHECK_EN && word != EXP_DAT && exp_err < 255) exp_err = exp_err + 1;
    end
    exp_miso = (nbits >= DW) ? TX_DAT : (TX_DAT >> (DW - nbits));

    check("rx_valid_pulses", 32'(valid_cnt - v0), 32'(nfull));
    check("frame_err_pulses", 32'(ferr_cnt - f0), 32'(1 - nfull));
    check("rx_dat", 32'(rx_dat), 32'(exp_rx));
    check("match", 32'(match), 32'(exp_match));
    check("err_cnt", 32'(err_cnt), 32'(exp_err));
    check("miso_word", 32'(miso_word), 32'(exp_miso));
    if (nbits >= DW) check("valid_latency", 32'(valid_cyc - rise_last), 32'd3);
    if (nbits > DW) check("miso_after_done", 32'(extra_or), 32'd0);
  endtask

  // Watchdog: the sequence below is time-bounded, this only guards against
  // an unexpected stall of the bench itself.
  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 95000 clk cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        mb, or_miso;
    int          v0, f0, nb, half;
    logic [11:0] w;

    rst  = 1'b1;
    sck  = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_miso", 32'(miso), 32'd0);
    check("reset_rx_dat", 32'(rx_dat), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_match", 32'(match), 32'd0);
    check("reset_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Directed frames at clk/16
    send_frame(12'h702, DW, 8);
    send_frame(12'h703, DW, 8);
    send_frame(12'h702, 5, 8);      // aborted after 5 bits
    send_frame(12'h702, DW, 8);
    send_frame(12'h702, DW + 2, 8); // two surplus SCK cycles

    // Reset in the middle of a frame with ss_n held low
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 6; i++) drive_bit(1'($urandom), 8, mb);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_miso", 32'(miso), 32'd0);
    check("midrst_rx_dat", 32'(rx_dat), 32'd0);
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    check("midrst_match", 32'(match), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    exp_rx    = '0;
    exp_match = 1'b0;
    exp_err   = 0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    or_miso = 1'b0;
    for (int i = 0; i < DW; i++) begin
      drive_bit(1'($urandom), 8, mb);
      or_miso = or_miso | mb;
    end
    repeat (8) @(negedge clk);
    check("lowss_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("lowss_no_frame_err", 32'(ferr_cnt - f0), 32'd0);
    check("lowss_miso", 32'(or_miso), 32'd0);
    check("lowss_rx_dat", 32'(rx_dat), 32'd0);
    ss_n = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(12'h5A3, DW, 8);

    // Randomised frames: word, length and SCK rate
    for (int k = 0; k < 25; k++) begin
      w = ($urandom_range(0, 3) == 0) ? EXP_DAT : 12'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DW - 1) : DW + $urandom_range(0, 2);
      half = $urandom_range(4, 10);
      send_frame(w, nb, half);
    end

    // Mismatch counter saturation at clk/8
    for (int k = 0; k < 300; k++) send_frame(12'h703, DW, 4);
    send_frame(12'h702, DW, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
